mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-owner arbiter and sequencer that shares one memory-bus port between the instruction-fetch requester and the data (load/store) requester of the RV32I core.
- Sits between the core and the memory controller.
- Serialises requests, runs the bus handshake (busy/valid), and returns read data and a one-cycle ack to the granted requester.
- Data has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while i_req is pending before fetch is forced; range 1..15.
- TIMEOUT_CYCLES, 255: cycles allowed in ISSUE+WAIT_RESP before abort; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch address.
- i_rdata  out  32  fetch read data, valid with i_ack.
- i_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, valid with d_ack.
- d_ack  out  1  one-cycle completion pulse for data.
- bus_req  out  1  bus request, high only in ISSUE.
- bus_we  out  1  write strobe, qualified by bus_req.
- bus_addr  out  32  granted address.
- bus_wdata  out  32  granted write data.
- bus_busy  in  1  bus cannot accept this cycle.
- bus_valid  in  1  transaction complete; bus_rdata valid.
- bus_rdata  in  32  bus read data.
- err  out  1  timeout flag, pulses with ack.

Behaviour:
- Reset (sampled at the edge):
  - State = IDLE; starve_cnt = 0.
  - All outputs 0, including i_rdata, d_rdata, bus_addr, bus_wdata and err.
  - Any in-flight transaction is abandoned with no ack.
  - A bus_valid arriving afterwards in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT_RESP, RESP.
- IDLE:
  - Arbitrate on sampled i_req/d_req.
  - On grant: capture owner (I/D), address, we and wdata into registers, then go to ISSUE.
  - Fetch grants force we = 0 and wdata = 0.
  - Requester inputs are ignored after capture.
- Arbitration rules:
  - d_req only -> D.
  - i_req only -> I.
  - Both -> D, unless starve_cnt == STARVE_MAX, then I.
  - starve_cnt increments on each D grant made while i_req = 1, saturating at STARVE_MAX.
  - starve_cnt clears on any I grant, or on a D grant made with i_req = 0.
- ISSUE:
  - bus_req = 1; bus_we/addr/wdata come from the captured registers.
  - bus_busy = 0 -> request accepted this cycle, go to WAIT_RESP.
  - bus_busy = 1 -> hold ISSUE with outputs unchanged.
  - bus_valid is ignored in ISSUE.
- WAIT_RESP:
  - bus_req = 0 and bus_we = 0; bus_addr/bus_wdata hold.
  - On bus_valid = 1 -> go to RESP.
  - For an I read, latch bus_rdata into i_rdata. For a D read, latch it into d_rdata.
  - For a D write, d_rdata is unchanged.
- RESP:
  - The owner's ack = 1 for exactly one cycle; the other ack = 0. Then go to IDLE.
- Requester rule:
  - Drop req at the edge where ack is seen.
  - req high in the IDLE cycle after RESP counts as a new request.
- Latency:
  - req sampled at edge 0 -> bus_req high in cycle 1.
  - Earliest bus_valid in cycle 2 -> ack in cycle 3.
  - Each busy cycle adds 1; each wait cycle before bus_valid adds 1.
- Only one transaction is ever outstanding; no pipelining.
- i_rdata/d_rdata hold their last value between acks.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to ISSUE and increments each cycle in ISSUE or WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES: go to RESP, assert err = 1 with the owner's ack, and set the owner's rdata to 0.
  - A later bus_valid is ignored.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; err is constant 0.
  - The arbiter waits indefinitely for bus_valid / !bus_busy.

Test Plan:
- Reset: rst = 1 for 2 cycles with d_req = i_req = 1 -> all outputs 0 and no bus_req. Release rst -> bus_req = 1 in the next cycle with bus_addr = d_addr.
- Fetch read: i_req = 1, i_addr = 0x100; bus_busy = 0; bus_valid with bus_rdata = 0x00A00093 two cycles after bus_req. Expect bus_we = 0, i_ack for 1 cycle, i_rdata = 0x00A00093, d_ack = 0.
- Store under busy: d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0xCAFEF00D; bus_busy = 1 for 3 cycles. Expect bus_req held for 4 cycles with addr/wdata stable, bus_we = 1, d_ack after bus_valid, d_rdata unchanged.
- Priority and starvation (STARVE_MAX = 4): both req held continuously, each ack followed by re-request. Expect grant order D, D, D, D, I, D…
- Reset mid-operation: assert rst in WAIT_RESP, then pulse bus_valid in the following IDLE cycle. Expect no ack, i/d_rdata = 0, state IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): d read with bus_valid never asserted. Expect d_ack = 1, err = 1, d_rdata = 0, eight cycles after ISSUE entry; without the macro, no ack ever.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and bus-side signals of the instruction/data
// memory arbiter. The arbiter uses the slave modport; the core/memory model
// side uses the master modport.
//
// Handshakes: i_req/d_req are levels held by the requester until the matching
// one-cycle i_ack/d_ack pulse. bus_req is held while bus_busy=1 and the
// request counts as accepted on the first edge where bus_req=1 and
// bus_busy=0. bus_valid completes the single outstanding transaction.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_busy;
  logic        bus_valid;
  logic [31:0] bus_rdata;
  logic        err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  bus_busy, bus_valid, bus_rdata,
    output i_rdata, i_ack, d_rdata, d_ack,
    output bus_req, bus_we, bus_addr, bus_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output bus_busy, bus_valid, bus_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack,
    input  bus_req, bus_we, bus_addr, bus_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-bus port between the instruction-fetch and
// the data requester. Data wins ties; a saturating starvation counter forces
// a fetch grant after STARVE_MAX consecutive data grants with fetch pending.
// One transaction outstanding at a time: IDLE -> ISSUE -> WAIT_RESP -> RESP.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, a transaction that
// spends TIMEOUT_CYCLES cycles in ISSUE+WAIT_RESP is aborted and acked with
// err=1 and zero read data. When undefined, err is tied to 0 and the arbiter
// waits indefinitely.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave mif,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Reject configurations the counters cannot represent.
  if (STARVE_MAX == 0 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic        owner_d;      // 1 = data requester owns the bus, 0 = fetch
  logic        we_q;         // captured write flag, survives WAIT_RESP
  logic [3:0]  starve_cnt;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        i_ack_q;
  logic        d_ack_q;
  logic        grant_d;
  logic        grant_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;
  logic             tmo_hit;

  // The counter holds TIMEOUT_CYCLES-1 during the last allowed cycle.
  assign tmo_hit = ((state == ISSUE) || (state == WAIT_RESP)) && (tmo_cnt == TMO_LAST);
  assign mif.err = err_q;
`else
  assign mif.err = 1'b0;
`endif

  // Arbitration on the sampled requests: data first unless fetch is starved.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (mif.d_req && !(mif.i_req && (starve_cnt == STARVE_LIM))) begin
      grant_d = 1'b1;
    end else if (mif.i_req) begin
      grant_i = 1'b1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      we_q        <= 1'b0;
      starve_cnt  <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q <= 1'b0;
      if ((state == ISSUE) || (state == WAIT_RESP)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) begin
        // Abort: ack the owner with err and zero data; any late bus_valid
        // lands in RESP/IDLE and is ignored.
        state     <= RESP;
        bus_req_q <= 1'b0;
        bus_we_q  <= 1'b0;
        err_q     <= 1'b1;
        if (owner_d) begin
          d_ack_q   <= 1'b1;
          d_rdata_q <= '0;
        end else begin
          i_ack_q   <= 1'b1;
          i_rdata_q <= '0;
        end
      end else
`endif
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d     <= 1'b1;
            we_q        <= mif.d_we;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mif.d_we;
            bus_addr_q  <= mif.d_addr;
            bus_wdata_q <= mif.d_wdata;
            state       <= ISSUE;
            if (!mif.i_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (grant_i) begin
            owner_d     <= 1'b0;
            we_q        <= 1'b0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= mif.i_addr;
            bus_wdata_q <= '0;
            starve_cnt  <= '0;
            state       <= ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        ISSUE: begin
          if (!mif.bus_busy) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mif.bus_valid) begin
            state <= RESP;
            if (owner_d) begin
              d_ack_q <= 1'b1;
              if (!we_q) begin
                d_rdata_q <= mif.bus_rdata;
              end
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= mif.bus_rdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mif.bus_req   = bus_req_q;
  assign mif.bus_we    = bus_we_q;
  assign mif.bus_addr  = bus_addr_q;
  assign mif.bus_wdata = bus_wdata_q;
  assign mif.i_rdata   = i_rdata_q;
  assign mif.d_rdata   = d_rdata_q;
  assign mif.i_ack     = i_ack_q;
  assign mif.d_ack     = d_ack_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch read, store under busy,
// short random transactions, priority/starvation order, reset mid-flight and
// the timeout behaviour (with or without MEM_ARB_TIMEOUT_EN).
module tb_mem_arbiter;
  localparam int W = 33;  // {owner_is_d, rdata}

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  mem_arbiter_if mif ();

  mem_arbiter #(
    .STARVE_MAX    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mif      (mif),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int          n_vec = 0;
  int          n_miss = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] grant_q[$];
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle the ack should be visible; pops the scoreboard.
  task automatic check_ack(input string tag, input logic exp_err);
    logic [W-1:0] e;
    chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_ack"}, {30'd0, mif.d_ack, mif.i_ack}, e[32] ? 32'd2 : 32'd1);
      chk({tag, "_rdata"}, e[32] ? mif.d_rdata : mif.i_rdata, e[31:0]);
      chk({tag, "_err"}, 32'(mif.err), 32'(exp_err));
    end
  endtask

  // Driver: one full transaction with the other requester idle.
  task automatic run_txn(input string tag, input logic is_d, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int busy_n, input int wait_n);
    logic [31:0] exp_rd;
    if (is_d) begin
      mif.d_req = 1'b1; mif.d_we = we; mif.d_addr = addr; mif.d_wdata = wdata;
    end else begin
      mif.i_req = 1'b1; mif.i_addr = addr;
    end
    tick();  // ISSUE
    chk({tag, "_bus_req"}, 32'(mif.bus_req), 32'd1);
    chk({tag, "_addr"}, mif.bus_addr, addr);
    chk({tag, "_we"}, 32'(mif.bus_we), 32'(is_d & we));
    chk({tag, "_wdata"}, mif.bus_wdata, is_d ? wdata : 32'd0);
    mif.bus_busy = (busy_n > 0);
    for (int i = 0; i < busy_n; i++) begin
      tick();
      chk({tag, "_busy_hold"}, {mif.bus_req, mif.bus_we, 30'd0}, {1'b1, is_d & we, 30'd0});
      chk({tag, "_busy_addr"}, mif.bus_addr ^ mif.bus_wdata, addr ^ (is_d ? wdata : 32'd0));
    end
    mif.bus_busy = 1'b0;
    tick();  // WAIT_RESP
    chk({tag, "_wait"}, {28'd0, mif.bus_req, mif.bus_we, dbg_state}, 32'd2);
    for (int i = 0; i < wait_n; i++) begin
      tick();
      chk({tag, "_no_ack"}, {30'd0, mif.d_ack, mif.i_ack}, 32'd0);
    end
    mif.bus_valid = 1'b1;
    mif.bus_rdata = rdata;
    exp_rd = (is_d && we) ? last_d : rdata;
    exp_q.push_back({is_d, exp_rd});
    if (is_d) last_d = exp_rd; else last_i = exp_rd;
    tick();  // RESP
    mif.bus_valid = 1'b0;
    mif.bus_rdata = $urandom;
    check_ack(tag, 1'b0);
    mif.d_req = 1'b0;
    mif.i_req = 1'b0;
    mif.d_we  = 1'b0;
    tick();  // IDLE
    chk({tag, "_idle"}, {28'd0, mif.d_ack, mif.i_ack, dbg_state}, 32'd0);
  endtask

  initial begin
    logic [31:0] e_addr;
    logic [31:0] rd;
    int          budget;

    rst = 1'b1;
    mif.i_req = 1'b1; mif.i_addr = 32'h400;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_addr = 32'h3000; mif.d_wdata = 32'h1234_5678;
    mif.bus_busy = 1'b0; mif.bus_valid = 1'b0; mif.bus_rdata = '0;

    // Reset with both requests asserted.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ctrl", {26'd0, mif.bus_req, mif.bus_we, mif.i_ack, mif.d_ack, dbg_state}, 32'd0);
      chk("rst_err", 32'(mif.err), 32'd0);
      chk("rst_rdata", mif.i_rdata | mif.d_rdata, 32'd0);
      chk("rst_bus", mif.bus_addr | mif.bus_wdata, 32'd0);
    end
    rst = 1'b0;
    mif.i_req = 1'b0;
    run_txn("post_rst", 1'b1, 1'b0, 32'h3000, 32'h1234_5678, 32'h1111_1111, 0, 0);

    // Fetch read, data two cycles after bus_req.
    run_txn("fetch", 1'b0, 1'b0, 32'h100, 32'h0, 32'h00A0_0093, 0, 1);

    // Store held off by three busy cycles; d_rdata must not change.
    run_txn("store", 1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D, 32'hDEAD_BEEF, 3, 0);

    // Short random transactions.
    for (int k = 0; k < 4; k++) begin
      run_txn("rand", 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              {$urandom_range(32'hFFFF, 0), 2'b00}, $urandom, $urandom,
              int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
    end

    // Reset while waiting for the response, then a stray bus_valid in IDLE.
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_addr = 32'h700;
    tick();
    tick();
    chk("midrst_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    mif.d_req = 1'b0;
    tick();
    rst = 1'b0;
    mif.bus_valid = 1'b1;
    mif.bus_rdata = 32'h5555_AAAA;
    tick();
    mif.bus_valid = 1'b0;
    last_i = '0;
    last_d = '0;
    chk("midrst_state", {28'd0, mif.bus_req, mif.d_ack, dbg_state}, 32'd0);
    chk("midrst_iack", 32'(mif.i_ack), 32'd0);
    chk("midrst_rdata", mif.i_rdata | mif.d_rdata, 32'd0);
    tick();
    chk("midrst_later", {30'd0, mif.d_ack, mif.i_ack}, 32'd0);

    // Both requesters held: expect D,D,D,D,I,D.
    for (int g = 0; g < 6; g++) grant_q.push_back(g == 4 ? 32'h500 : 32'h600);
    mif.i_req = 1'b1; mif.i_addr = 32'h500;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_addr = 32'h600;
    for (int g = 0; g < 6; g++) begin
      budget = 0;
      do begin
        tick();
        budget++;
      end while (!mif.bus_req && budget < 10);
      chk("starve_bus_req", 32'(mif.bus_req), 32'd1);
      e_addr = grant_q.pop_front();
      chk("starve_grant", mif.bus_addr, e_addr);
      tick();
      rd = $urandom;
      mif.bus_valid = 1'b1;
      mif.bus_rdata = rd;
      exp_q.push_back({(e_addr != 32'h500), rd});
      tick();
      mif.bus_valid = 1'b0;
      if (g == 5) begin
        mif.i_req = 1'b0;
        mif.d_req = 1'b0;
      end
      check_ack("starve", 1'b0);
    end
    tick();
    tick();
    chk("starve_done", {31'd0, mif.bus_req}, 32'd0);

    // Data read whose response never arrives.
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_addr = 32'h40;
    tick();
    chk("tmo_issue", 32'(mif.bus_req), 32'd1);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("tmo_no_ack", {30'd0, mif.d_ack, mif.i_ack}, 32'd0);
    end
    exp_q.push_back({1'b1, 32'd0});
    tick();
    mif.d_req = 1'b0;
    check_ack("tmo", 1'b1);
    tick();
    mif.bus_valid = 1'b1;
    mif.bus_rdata = 32'h7777_7777;
    tick();
    mif.bus_valid = 1'b0;
    chk("tmo_late_valid", {30'd0, mif.d_ack, mif.i_ack}, 32'd0);
    chk("tmo_rdata_kept", mif.d_rdata, 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("notmo_no_ack", {29'd0, mif.err, mif.d_ack, mif.i_ack}, 32'd0);
    end
    chk("notmo_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    mif.d_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
